// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the detector bench:
// the two-state FSM encoding and the default parallel word width.
package seq_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/seq_bit_counter.sv
// Bit position counter for the serializer: restarts at 0 on every accepted word
// and flags the last payload bit (count == WIDTH-1).
module seq_bit_counter
    import seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic advance,
    output logic last
);

    logic [CNT_W-1:0] count;

    assign last = (count == CNT_W'(WIDTH - 1));

    // Wrap explicitly on the last bit so non-power-of-two widths never overrun.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (advance) begin
            count <= last ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter feeding the sequence detector, MSB first by default.
// Define SER_LSB_FIRST_EN to shift LSB first; timing is identical in both builds.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             busy
);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic             last;
    logic             transfer;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] load_rest;
    logic [WIDTH-1:0] shifted;

    assign data_ready = (state == IDLE) || last;
    assign transfer   = data_valid && data_ready;

`ifdef SER_LSB_FIRST_EN
    assign first_bit = data_in[0];
    assign load_rest = data_in >> 1;
    assign next_bit  = shreg[0];
    assign shifted   = shreg >> 1;
`else
    assign first_bit = data_in[WIDTH-1];
    assign load_rest = data_in << 1;
    assign next_bit  = shreg[WIDTH-1];
    assign shifted   = shreg << 1;
`endif

    seq_bit_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (transfer),
        .advance(state == SHIFT),
        .last   (last)
    );

    // The first bit goes straight to bit_out on the accepting edge; the rest
    // of the word waits in shreg, so a back-to-back word needs no bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (transfer) begin
            state     <= SHIFT;
            shreg     <= load_rest;
            bit_out   <= first_bit;
            bit_valid <= 1'b1;
            busy      <= 1'b1;
        end else if (state == SHIFT) begin
            if (last) begin
                state     <= IDLE;
                shreg     <= '0;
                bit_out   <= 1'b0;
                bit_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                shreg   <= shifted;
                bit_out <= next_bit;
            end
        end
    end

endmodule

// File: doc/seq_bit_serializer.md
SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

Interface
REQ-001: Parameter WIDTH, default 8, SHALL set the bits per parallel word (legal range 2..32).
REQ-002: clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003: rst  input  1  SHALL be the asynchronous, active-low reset (0 = reset asserted).
REQ-004: data_in  input  WIDTH  SHALL be the parallel word offered by the upstream producer.
REQ-005: data_valid  input  1  SHALL indicate data_in holds a word to transfer.
REQ-006: data_ready  output  1  SHALL indicate the block accepts a word this cycle.
REQ-007: bit_out  output  1  SHALL be the serial bit stream driven into the downstream sequence detector's serial input.
REQ-008: bit_valid  output  1  SHALL be high while bit_out carries a payload bit.
REQ-009: busy  output  1  SHALL be high whenever a word is being shifted.

Function
REQ-010: FSM states SHALL be IDLE and SHIFT only; reset state IDLE.
REQ-011: A transfer SHALL occur on a rising edge where data_valid and data_ready are both 1; no other condition loads the shift register.
REQ-012: data_ready SHALL be combinational: 1 in IDLE; 1 in SHIFT only during the last bit (bit counter = WIDTH-1); 0 otherwise.
REQ-013: On a transfer, the first payload bit SHALL appear on bit_out in the cycle immediately after the accepting edge (latency 1 cycle), with bit_valid = 1.
REQ-014: Each payload bit SHALL be held on bit_out for exactly one clock cycle; WIDTH consecutive cycles per word.
REQ-015: Default bit order SHALL be MSB first (data_in[WIDTH-1] first, data_in[0] last).
REQ-016: IDLE to SHIFT on transfer; SHIFT to SHIFT on last bit with a transfer (back-to-back, zero bubble); SHIFT to IDLE on last bit without a transfer.
REQ-017: In IDLE, bit_out SHALL be 0 and bit_valid 0, so the detector sees a quiet 0 line.
REQ-018: bit_out, bit_valid and busy SHALL be registered outputs; busy equals (state == SHIFT).
REQ-019: Changes on data_in/data_valid while data_ready = 0 SHALL have no effect.
REQ-020: Bit counter SHALL be $clog2(WIDTH) bits wide, counting 0..WIDTH-1 and wrapping to 0 on every transfer.

Reset
REQ-021: Asserting rst SHALL immediately force state IDLE, shift register 0, counter 0, bit_out 0, bit_valid 0, busy 0, independent of clk.
REQ-022: Reset mid-word SHALL discard the remaining bits; no partial word resumes after release.
REQ-023: First transfer after release SHALL be possible on the first rising edge with rst = 1.

Configuration
REQ-024: Macro SER_LSB_FIRST_EN, when defined, SHALL make bit order LSB first (data_in[0] first); when undefined, MSB first per REQ-015; all timing identical in both builds.

Structure
REQ-025: Package seq_pkg SHALL hold the state enum (IDLE, SHIFT) and the default word width constant, shared with the detector bench.
REQ-026: The bit counter with its last-bit flag SHALL be a sub-module, seq_bit_counter; the FSM and shift register remain in the top module.

Verification
REQ-027: Reset, then data_in = 8'hA5 with data_valid for one cycle -> bit_out 1,0,1,0,0,1,0,1 with bit_valid = 1 for 8 cycles, then 0/0.
REQ-028: data_valid held high with 8'hAA then 8'h55 -> 16 contiguous valid bits 1010101001010101, data_ready high only in IDLE and on each last-bit cycle.
REQ-029: Feed 8'h0A into the serializer -> seq detector: downstream out pulses once after the final 0 (pattern 1010 in the stream).
REQ-030: rst driven low after the 3rd bit of 8'hFF -> bit_out, bit_valid and busy go 0 at once, without waiting for a clk edge; after release the next word 8'h81 serializes fully as 1,0,0,0,0,0,0,1.
REQ-031: data_valid raised mid-word with changing data_in -> no effect on bit_out; the word is captured only on the last-bit cycle.
REQ-032: Build with SER_LSB_FIRST_EN, data_in = 8'h01 -> bit_out 1,0,0,0,0,0,0,0.
